// File: rtl/mul_accumulator.sv
// Multiply-accumulate back end: sums N consecutive products from the multiplier
// and offers the total on a valid/ready port, holding off new products until it is taken.
module mul_accumulator #(
    parameter  int PROD_W = 16,
    parameter  int N      = 4,
    localparam int SUM_W  = PROD_W + $clog2(N),
    localparam int CNT_W  = $clog2(N) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    input  logic              clear,
    output logic [SUM_W-1:0]  sum,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [CNT_W-1:0]  acc_cnt,
    output logic              busy,
    output logic              drop_err
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t            state, n_state;
    logic [SUM_W-1:0]  acc, n_acc, n_sum, prod_ext, acc_nxt;
    logic [CNT_W-1:0]  n_cnt;
    logic              n_sv, n_busy, n_drop;

    assign prod_ext = SUM_W'(prod);
    assign acc_nxt  = acc + prod_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            acc       <= '0;
            acc_cnt   <= '0;
            sum       <= '0;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            state     <= n_state;
            acc       <= n_acc;
            acc_cnt   <= n_cnt;
            sum       <= n_sum;
            sum_valid <= n_sv;
            busy      <= n_busy;
            drop_err  <= n_drop;
        end
    end

    always_comb begin
        n_state = state;
        n_acc   = acc;
        n_cnt   = acc_cnt;
        n_sum   = sum;
        n_sv    = sum_valid;
        n_busy  = busy;
        n_drop  = drop_err;
        if (clear) begin
            // abort wins over both handshakes; sum keeps its last delivered value
            n_state = ACCUM;
            n_acc   = '0;
            n_cnt   = '0;
            n_sv    = 1'b0;
            n_busy  = 1'b0;
            n_drop  = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (prod_valid) begin
                        if (acc_cnt == CNT_W'(N - 1)) begin
                            n_sum   = acc_nxt;
                            n_sv    = 1'b1;
                            n_busy  = 1'b1;
                            n_acc   = '0;
                            n_cnt   = '0;
                            n_state = HOLD;
                        end else begin
                            n_acc = acc_nxt;
                            n_cnt = acc_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (sum_ready) begin
                        n_sv    = 1'b0;
                        n_busy  = 1'b0;
                        n_state = ACCUM;
                        // a product coinciding with the transfer opens the next burst
                        if (prod_valid) begin
                            n_acc = prod_ext;
                            n_cnt = CNT_W'(1);
                        end
                    end else if (prod_valid) begin
                        n_drop = 1'b1;
                    end
                end
                default: n_state = ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench for mul_accumulator: linear steps with hand-computed expectations.
module tb_mul_accumulator;

    logic        clk = 1'b0;
    logic        reset, prod_valid, clear, sum_ready;
    logic [15:0] prod;
    logic [17:0] sum;
    logic        sum_valid, busy, drop_err;
    logic [2:0]  acc_cnt;

    int total = 0;
    int bad   = 0;

    mul_accumulator dut (
        .clk        (clk),
        .reset      (reset),
        .prod       (prod),
        .prod_valid (prod_valid),
        .clear      (clear),
        .sum        (sum),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .acc_cnt    (acc_cnt),
        .busy       (busy),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // advance one edge, then settle so outputs are sampled away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] p);
        prod       = p;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".sum"}, 32'(sum), 0);
        chk({tag, ".sv"}, 32'(sum_valid), 0);
        chk({tag, ".cnt"}, 32'(acc_cnt), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".drop"}, 32'(drop_err), 0);
    endtask

    initial begin
        reset = 1'b1; prod_valid = 1'b0; clear = 1'b0; sum_ready = 1'b1; prod = '0;
        tick();
        tick();
        reset = 1'b0;
        chk_zero("rst");

        // 1: basic burst
        send(40);  chk("t1.cnt1", 32'(acc_cnt), 1);
        send(72);  chk("t1.cnt2", 32'(acc_cnt), 2);
        send(128); chk("t1.cnt3", 32'(acc_cnt), 3); chk("t1.sv_early", 32'(sum_valid), 0);
        send(96);
        chk("t1.sum", 32'(sum), 336);
        chk("t1.sv", 32'(sum_valid), 1);
        chk("t1.busy", 32'(busy), 1);
        chk("t1.cnt0", 32'(acc_cnt), 0);
        tick();
        chk("t1.sv_drop", 32'(sum_valid), 0);
        chk("t1.busy_drop", 32'(busy), 0);
        chk("t1.sum_hold", 32'(sum), 336);

        // 2: max products with gaps
        send(65025);
        send(65025); chk("t2.cnt2", 32'(acc_cnt), 2);
        idle(2);     chk("t2.gap2", 32'(acc_cnt), 2);
        send(65025); chk("t2.cnt3", 32'(acc_cnt), 3);
        idle(5);     chk("t2.gap5", 32'(acc_cnt), 3);
        send(65025);
        chk("t2.sum", 32'(sum), 260100);
        chk("t2.sv", 32'(sum_valid), 1);
        tick();

        // 3: stall in HOLD, product dropped
        sum_ready = 1'b0;
        send(40); send(72); send(128); send(96);
        chk("t3.sum", 32'(sum), 336);
        idle(2);
        send(10);
        idle(3);
        chk("t3.sum_hold", 32'(sum), 336);
        chk("t3.sv_hold", 32'(sum_valid), 1);
        chk("t3.busy", 32'(busy), 1);
        chk("t3.drop", 32'(drop_err), 1);
        chk("t3.cnt", 32'(acc_cnt), 0);
        sum_ready = 1'b1;
        tick();
        chk("t3.sv_done", 32'(sum_valid), 0);
        chk("t3.drop_sticky", 32'(drop_err), 1);
        send(5); send(6); send(7); send(8);
        chk("t3.next_sum", 32'(sum), 26);
        chk("t3.drop_sticky2", 32'(drop_err), 1);
        tick();

        // 4: ready and product in the same HOLD cycle
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t4.clr_drop", 32'(drop_err), 0);
        sum_ready = 1'b0;
        send(1); send(1); send(1); send(1);
        chk("t4.sum_a", 32'(sum), 4);
        chk("t4.sv_a", 32'(sum_valid), 1);
        sum_ready = 1'b1;
        send(50);
        chk("t4.sv_off", 32'(sum_valid), 0);
        chk("t4.cnt1", 32'(acc_cnt), 1);
        chk("t4.nodrop", 32'(drop_err), 0);
        send(1); send(1); send(1);
        chk("t4.sum", 32'(sum), 53);
        chk("t4.drop_end", 32'(drop_err), 0);
        tick();

        // 5: clear beats a coincident product
        send(40); send(72);
        chk("t5.cnt2", 32'(acc_cnt), 2);
        clear = 1'b1; prod = 99; prod_valid = 1'b1;
        tick();
        clear = 1'b0; prod_valid = 1'b0;
        chk("t5.cnt0", 32'(acc_cnt), 0);
        chk("t5.drop", 32'(drop_err), 0);
        chk("t5.sv", 32'(sum_valid), 0);
        send(1); send(1); send(1); send(1);
        chk("t5.sum", 32'(sum), 4);
        tick();

        // 6: reset in HOLD (with drop set), then mid-burst
        sum_ready = 1'b0;
        send(2); send(2); send(2); send(2);
        chk("t6.sum", 32'(sum), 8);
        send(7);
        chk("t6.drop", 32'(drop_err), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_zero("t6.rst_hold");
        sum_ready = 1'b1;
        send(3); send(3);
        chk("t6.cnt2", 32'(acc_cnt), 2);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_zero("t6.rst_mid");
        send(1); send(2); send(3); send(4);
        chk("t6.sum_fresh", 32'(sum), 10);
        chk("t6.sv_fresh", 32'(sum_valid), 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_accumulator.md
Name: mul_accumulator

Overview:
Downstream stage of the 8x8 multiplier. Consumes each 16-bit product qualified by the multiplier's ack, sums N consecutive products into a wider result, and presents the result on a valid/ready output handshake. Gives the multiplier path multiply-accumulate capability without changing the multiplier.

Parameters:
PROD_W, 16, product input width; matches the multiplier out width.
N, 4, products per accumulation burst; power of two, N >= 2.
SUM_W, PROD_W+$clog2(N), derived localparam, not overridable; result width, cannot overflow.
CNT_W, $clog2(N)+1, derived localparam; width of the burst counter.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous active-high reset.
prod  input  PROD_W  product from the multiplier (out).
prod_valid  input  1  multiplier ack; each cycle it is high is one product.
clear  input  1  synchronous abort; zeroes the burst.
sum  output  SUM_W  accumulated result; stable while sum_valid is high.
sum_valid  output  1  result available.
sum_ready  input  1  consumer accepts the result.
acc_cnt  output  CNT_W  products accumulated in the current burst.
busy  output  1  high in HOLD; products are not accepted.
drop_err  output  1  sticky flag: a product arrived while in HOLD.

Behaviour:
- Reset is synchronous and active-high: reset high at a clk edge forces state=ACCUM, acc=0, acc_cnt=0, sum=0, sum_valid=0, busy=0, drop_err=0. Reset overrides all other inputs, including during HOLD or mid-burst.
- States: ACCUM and HOLD.
- ACCUM, prod_valid=1, acc_cnt<N-1:
  - acc <= acc + zero-extended prod.
  - acc_cnt++.
- ACCUM, prod_valid=1, acc_cnt==N-1 (Nth product):
  - sum <= acc + prod; sum_valid <= 1; busy <= 1.
  - acc <= 0; acc_cnt <= 0; go to HOLD.
  - Latency: sum_valid rises on the edge after the Nth product is sampled, i.e. 1 cycle.
- ACCUM, prod_valid=0: hold acc and acc_cnt. Gaps between products are allowed.
- HOLD, sum_ready=0:
  - sum and sum_valid hold.
  - Any prod_valid=1 sets drop_err <= 1; the product is discarded.
- HOLD, sum_ready=1:
  - sum_valid <= 0; busy <= 0; go to ACCUM.
  - If prod_valid=1 in the same cycle, that product is accepted as the first of the next burst (acc <= prod, acc_cnt <= 1) and drop_err is not set.
- Handshake: transfer occurs on a cycle where sum_valid & sum_ready are both high. sum_ready is ignored when sum_valid=0. sum holds its last value after the transfer until the next burst completes.
- clear=1, when reset=0:
  - acc <= 0; acc_cnt <= 0; sum_valid <= 0; busy <= 0; drop_err <= 0; state <= ACCUM.
  - Any prod_valid in the same cycle is discarded.
  - clear has priority over prod_valid and sum_ready.
- Arithmetic: unsigned, no saturation needed. Maximum total is N*(2^PROD_W-1) < 2^SUM_W.
- Only drop_err is sticky; it is cleared only by reset or clear.

Test Plan:
1. Reset, then prod_valid pulses with prod=40, 72, 128, 96 and sum_ready=1 -> acc_cnt steps 1,2,3; sum_valid high 1 cycle after the 4th product with sum=336; busy high in that cycle only.
2. Max values: four products of 65025 (255*255), with idle gaps of 0, 2 and 5 cycles between them -> sum=260100, no wrap; acc_cnt holds across the gaps.
3. Complete a burst summing to 336, keep sum_ready=0 for 6 cycles, pulse prod_valid with prod=10 during HOLD -> sum stays 336, drop_err=1 and remains set after sum_ready=1; the next burst does not include 10.
4. In HOLD, assert sum_ready=1 together with prod_valid=1, prod=50; then send three products of 1 -> no drop_err; the next sum=53.
5. After two products (40, 72), assert clear together with prod_valid, prod=99 -> acc_cnt=0; drop_err=0; the next four products of 1 give sum=4.
6. During HOLD (sum_valid=1) and separately mid-burst (acc_cnt=2), assert reset for 1 cycle -> all outputs 0 on the following edge; the next full burst accumulates from zero.
